fsm_enchimento: RTL and testbench
=================================

// Module: fsm_enchimento
// PURPOSE
//  Moore FSM for the filling stage, directly upstream of bottle sealing.
//  Waits for a seated bottle, opens the wine valve, closes it on the level sensor.
//  Asserts GARRAFA_CHEIA, which the sealing FSM consumes.
//  Detects timeout, bottle removal and empty-tank faults; counts filled bottles.
// PARAMETERS
//  TEMPO_ASSENTAMENTO   4     cycles GARRAFA_PRESENTE must stay high before filling
//  TEMPO_MAX_ENCHIMENTO 1000  cycle budget in ENCHENDO before a timeout fault
//  W_TEMP               10    timer width; must satisfy 2^W_TEMP > max(both times)
//  W_CONT               16    width of the filled-bottle counter
// PORTS
//  CLOCK             in   1       single system clock, rising edge
//  RESET             in   1       asynchronous, active-low reset
//  HABILITA          in   1       line run enable
//  GARRAFA_PRESENTE  in   1       bottle at filling position
//  SENSOR_NIVEL      in   1       level sensor; 1 = target level reached
//  VINHO_DISPONIVEL  in   1       supply tank not empty
//  RECONHECE_ERRO    in   1       operator acknowledge of a fault
//  VALVULA_ABERTA    out  1       wine valve command
//  GARRAFA_CHEIA     out  1       bottle full; to the sealing stage
//  ERRO_ENCHIMENTO   out  1       fault flag
//  CONT_GARRAFAS     out  W_CONT  count of bottles filled
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - state = OCIOSO; timer = 0; CONT_GARRAFAS = 0
//   - all 1-bit outputs = 0 (valve closes immediately)
//  All outputs are registered or decoded from registered state only (Moore).
//  OCIOSO:
//   - HABILITA & GARRAFA_PRESENTE -> ASSENTANDO; timer cleared.
//  ASSENTANDO (timer counts each cycle):
//   - !GARRAFA_PRESENTE | !HABILITA -> OCIOSO.
//   - Else, timer == TEMPO_ASSENTAMENTO-1 & VINHO_DISPONIVEL -> ENCHENDO; timer cleared.
//   - Else, timer expired & !VINHO_DISPONIVEL: hold; timer saturates.
//  ENCHENDO (VALVULA_ABERTA = 1; timer counts). Priority, highest first:
//   1. !GARRAFA_PRESENTE -> ERRO
//   2. SENSOR_NIVEL -> CHEIA; CONT_GARRAFAS += 1 on that same edge
//   3. timer == TEMPO_MAX_ENCHIMENTO-1 -> ERRO
//   4. !VINHO_DISPONIVEL | !HABILITA -> ERRO
//   - Valve closes and GARRAFA_CHEIA rises one cycle after SENSOR_NIVEL is sampled high.
//  CHEIA (GARRAFA_CHEIA = 1):
//   - Ignores HABILITA and sensors.
//   - !GARRAFA_PRESENTE -> OCIOSO; GARRAFA_CHEIA drops on the next edge.
//  ERRO (ERRO_ENCHIMENTO = 1; valve closed):
//   - RECONHECE_ERRO & !GARRAFA_PRESENTE -> OCIOSO.
//   - Ack with the bottle still present is ignored.
//  CONT_GARRAFAS wraps modulo 2^W_CONT; it is never cleared except by reset.
//  Undefined state encodings -> OCIOSO.
//  VALVULA_ABERTA and GARRAFA_CHEIA are never high together.
// STRUCTURE
//  - vinho_defs.vh: state encodings (OCIOSO..ERRO, 3 bits), shared with other line FSMs.
//  - Sub-module temporizador (W_TEMP):
//    - inputs: clear, enable; input LIMITE; output FIM = (count == LIMITE).
//    - Saturates at LIMITE.
//    - One instance, reloaded per state (LIMITE muxed by state).
//  - Top: next-state always @(*), state/counter registers, output decode.
// TESTING (bench parameters: TEMPO_ASSENTAMENTO=4, TEMPO_MAX_ENCHIMENTO=20)
//  1. Nominal: HABILITA=1, PRESENTE=1 at cycle 0; NIVEL=1 at cycle 10.
//     -> valve high cycles 5..10, GARRAFA_CHEIA=1 from cycle 11, CONT=1.
//     -> PRESENTE=0 -> CHEIA drops next cycle.
//  2. Bottle bounce: PRESENTE high 2 cycles then low
//     -> valve never opens; state returns to OCIOSO; CONT unchanged.
//  3. Timeout: NIVEL held 0
//     -> valve open exactly 20 cycles, then ERRO_ENCHIMENTO=1, valve=0.
//     -> ack with bottle present ignored; ack after removal -> OCIOSO.
//  4. Simultaneous: NIVEL=1 on the timeout cycle -> CHEIA, no error.
//     Removal with NIVEL=1 on the same cycle -> ERRO.
//  5. Tank empty: VINHO_DISPONIVEL=0 during seating -> holds, valve stays closed.
//     Drop during fill -> ERRO.
//  6. Async reset mid-fill -> valve=0 without a clock edge; CONT=0.
//     Counter wrap: preload 16'hFFFF via 65535 fills (or force) -> next fill gives 0.

Source files
------------

// File: rtl/fsm_enchimento_pkg.sv
// Shared definitions for the filling-stage controller.
// Holds the 3-bit state encoding. The other line FSMs use the same values,
// so existing encodings must not be renumbered.
package fsm_enchimento_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,  // waiting for a bottle
    ASSENTANDO = 3'd1,  // bottle seating, waiting for it to settle
    ENCHENDO   = 3'd2,  // valve open, filling
    CHEIA      = 3'd3,  // bottle full, waiting for removal by the sealer
    ERRO       = 3'd4   // fault latched until acknowledged with no bottle
  } estado_t;

endpackage

// File: rtl/fsm_enchimento_temporizador.sv
// Saturating up-counter used by the filling FSM for its seating delay and
// its fill timeout.
// Ports:
//   CLOCK   in   rising-edge clock
//   RESET   in   asynchronous active-low reset
//   clear   in   synchronous clear, takes priority over enable
//   enable  in   count one step per cycle while below LIMITE
//   LIMITE  in   W_TEMP-bit terminal value; the counter stops here
//   FIM     out  count == LIMITE
module fsm_enchimento_temporizador #(
  parameter int W_TEMP = 10
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              enable,
  input  logic [W_TEMP-1:0] LIMITE,
  output logic              FIM
);

  logic [W_TEMP-1:0] count;

  // The less-than test stops the counter at LIMITE. It also keeps a stale
  // count above a newly selected limit from wrapping around.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count < LIMITE)) begin
      count <= count + 1'b1;
    end
  end

  assign FIM = (count == LIMITE);

endmodule

// File: rtl/fsm_enchimento.sv
// Moore FSM for the filling stage, directly upstream of bottle sealing.
// It waits for a bottle to settle in position and then opens the wine valve.
// The valve closes when the level sensor reports the target level, and the
// FSM then reports the bottle as full to the sealing stage. Timeouts, bottle
// removal and an empty tank are latched as faults. The FSM also counts the
// bottles it fills.
//
// There is no valid/ready handshake. GARRAFA_CHEIA is a level that stays
// high from the cycle after the level sensor trips until the bottle leaves
// the position. The sealing stage samples it as a plain level.
//
// Ports:
//   CLOCK             in   rising-edge system clock
//   RESET             in   asynchronous active-low reset
//   HABILITA          in   line run enable
//   GARRAFA_PRESENTE  in   bottle at the filling position
//   SENSOR_NIVEL      in   1 = target level reached
//   VINHO_DISPONIVEL  in   supply tank not empty
//   RECONHECE_ERRO    in   operator fault acknowledge
//   VALVULA_ABERTA    out  wine valve command
//   GARRAFA_CHEIA     out  bottle full, to the sealing stage
//   ERRO_ENCHIMENTO   out  fault flag
//   CONT_GARRAFAS     out  filled-bottle count, wraps modulo 2^W_CONT
//   estado            out  current state encoding (debug)
module fsm_enchimento
  import fsm_enchimento_pkg::*;
#(
  parameter int TEMPO_ASSENTAMENTO   = 4,
  parameter int TEMPO_MAX_ENCHIMENTO = 1000,
  parameter int W_TEMP               = 10,
  parameter int W_CONT               = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              HABILITA,
  input  logic              GARRAFA_PRESENTE,
  input  logic              SENSOR_NIVEL,
  input  logic              VINHO_DISPONIVEL,
  input  logic              RECONHECE_ERRO,
  output logic              VALVULA_ABERTA,
  output logic              GARRAFA_CHEIA,
  output logic              ERRO_ENCHIMENTO,
  output logic [W_CONT-1:0] CONT_GARRAFAS,
  output logic [2:0]        estado
);

  localparam logic [W_TEMP-1:0] LIM_ASSENT = W_TEMP'(TEMPO_ASSENTAMENTO - 1);
  localparam logic [W_TEMP-1:0] LIM_ENCH   = W_TEMP'(TEMPO_MAX_ENCHIMENTO - 1);

  estado_t           estado_atual;
  estado_t           estado_prox;
  logic              incrementa;
  logic              temp_clear;
  logic              temp_enable;
  logic              temp_fim;
  logic [W_TEMP-1:0] temp_limite;
  logic [W_CONT-1:0] cont;

  // One timer serves both timed states. Its limit follows the current
  // state. It restarts from zero on every state change, so each timed
  // state starts counting at 0.
  assign temp_clear  = (estado_prox != estado_atual);
  assign temp_enable = (estado_atual == ASSENTANDO) || (estado_atual == ENCHENDO);
  assign temp_limite = (estado_atual == ASSENTANDO) ? LIM_ASSENT : LIM_ENCH;

  fsm_enchimento_temporizador #(
    .W_TEMP (W_TEMP)
  ) u_temporizador (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clear  (temp_clear),
    .enable (temp_enable),
    .LIMITE (temp_limite),
    .FIM    (temp_fim)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      estado_atual <= OCIOSO;
    end else begin
      estado_atual <= estado_prox;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cont <= '0;
    end else if (incrementa) begin
      cont <= cont + 1'b1;
    end
  end

  always_comb begin
    estado_prox = estado_atual;
    incrementa  = 1'b0;
    case (estado_atual)
      OCIOSO: begin
        if (HABILITA && GARRAFA_PRESENTE) estado_prox = ASSENTANDO;
      end
      ASSENTANDO: begin
        // When the tank is empty the timer stays saturated, and filling
        // starts as soon as wine becomes available.
        if (!GARRAFA_PRESENTE || !HABILITA) estado_prox = OCIOSO;
        else if (temp_fim && VINHO_DISPONIVEL) estado_prox = ENCHENDO;
      end
      ENCHENDO: begin
        // A level reached on the last allowed cycle still counts as a
        // good fill, because the level test comes before the timeout test.
        if (!GARRAFA_PRESENTE) begin
          estado_prox = ERRO;
        end else if (SENSOR_NIVEL) begin
          estado_prox = CHEIA;
          incrementa  = 1'b1;
        end else if (temp_fim) begin
          estado_prox = ERRO;
        end else if (!VINHO_DISPONIVEL || !HABILITA) begin
          estado_prox = ERRO;
        end
      end
      CHEIA: begin
        if (!GARRAFA_PRESENTE) estado_prox = OCIOSO;
      end
      ERRO: begin
        if (RECONHECE_ERRO && !GARRAFA_PRESENTE) estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // The outputs are decoded only from the state register. Each output has
  // its own state, so the valve and the full flag are never high together.
  assign VALVULA_ABERTA  = (estado_atual == ENCHENDO);
  assign GARRAFA_CHEIA   = (estado_atual == CHEIA);
  assign ERRO_ENCHIMENTO = (estado_atual == ERRO);
  assign CONT_GARRAFAS   = cont;
  assign estado          = estado_atual;

endmodule

// File: tb/tb_fsm_enchimento.sv
module tb_fsm_enchimento;
  import fsm_enchimento_pkg::*;

  localparam int TA = 4;
  localparam int TM = 20;
  localparam int WT = 10;
  localparam int WC = 8;

  // ---------------- clock / reset ----------------
  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          HABILITA, GARRAFA_PRESENTE, SENSOR_NIVEL, VINHO_DISPONIVEL, RECONHECE_ERRO;
  logic          VALVULA_ABERTA, GARRAFA_CHEIA, ERRO_ENCHIMENTO;
  logic [WC-1:0] CONT_GARRAFAS;
  logic [2:0]    estado;

  always #5 CLOCK = ~CLOCK;

  fsm_enchimento #(
    .TEMPO_ASSENTAMENTO   (TA),
    .TEMPO_MAX_ENCHIMENTO (TM),
    .W_TEMP               (WT),
    .W_CONT               (WC)
  ) dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .HABILITA         (HABILITA),
    .GARRAFA_PRESENTE (GARRAFA_PRESENTE),
    .SENSOR_NIVEL     (SENSOR_NIVEL),
    .VINHO_DISPONIVEL (VINHO_DISPONIVEL),
    .RECONHECE_ERRO   (RECONHECE_ERRO),
    .VALVULA_ABERTA   (VALVULA_ABERTA),
    .GARRAFA_CHEIA    (GARRAFA_CHEIA),
    .ERRO_ENCHIMENTO  (ERRO_ENCHIMENTO),
    .CONT_GARRAFAS    (CONT_GARRAFAS),
    .estado           (estado)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic h, input logic p, input logic n, input logic v, input logic a);
    HABILITA         = h;
    GARRAFA_PRESENTE = p;
    SENSOR_NIVEL     = n;
    VINHO_DISPONIVEL = v;
    RECONHECE_ERRO   = a;
  endtask

  // From idle: bottle seats for TA cycles, then the valve opens.
  task automatic start_fill(input string name);
    drive(1, 1, 0, 1, 0);
    repeat (TA + 1) tick();
    chk(name, 32'(VALVULA_ABERTA), 32'd1);
  endtask

  // Unchecked complete fill cycle used to step the counter quickly.
  task automatic fill_one();
    drive(1, 1, 0, 1, 0);
    repeat (TA + 1) tick();
    drive(1, 1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          h, p, n, v, a;
    logic          ev, ec, ee;
    logic [WC-1:0] ecnt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic h, input logic p, input logic n, input logic v,
                              input logic a, input logic ev, input logic ec, input logic ee,
                              input int c);
    vec_t r;
    r.h = h; r.p = p; r.n = n; r.v = v; r.a = a;
    r.ev = ev; r.ec = ec; r.ee = ee; r.ecnt = WC'(c);
    return r;
  endfunction

  // ---------------- reference model ----------------
  // The model tracks the bottle's stage and the number of cycles it has
  // spent in that stage as plain integers. The count is kept modulo 2^WC.
  localparam int ST_IDLE = 0, ST_SEAT = 1, ST_FILL = 2, ST_FULL = 3, ST_FAULT = 4;
  int m_stage, m_cycles, m_filled;

  task automatic model_step(input logic h, input logic p, input logic n, input logic v, input logic a);
    case (m_stage)
      ST_IDLE:  if (h && p) begin m_stage = ST_SEAT; m_cycles = 0; end
      ST_SEAT: begin
        if (!p || !h) m_stage = ST_IDLE;
        else if (m_cycles >= TA - 1 && v) begin m_stage = ST_FILL; m_cycles = 0; end
        else m_cycles++;
      end
      ST_FILL: begin
        if (!p) m_stage = ST_FAULT;
        else if (n) begin m_stage = ST_FULL; m_filled = (m_filled + 1) % (1 << WC); end
        else if (m_cycles == TM - 1) m_stage = ST_FAULT;
        else if (!v || !h) m_stage = ST_FAULT;
        else m_cycles++;
      end
      ST_FULL:  if (!p) m_stage = ST_IDLE;
      default:  if (a && !p) m_stage = ST_IDLE;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [WC+2:0] exp_q[$];

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_open;
    logic p_r;
    logic [WC+2:0] got, expv;

    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("reset_valve", 32'(VALVULA_ABERTA), 32'd0);
    chk("reset_cheia", 32'(GARRAFA_CHEIA), 32'd0);
    chk("reset_erro", 32'(ERRO_ENCHIMENTO), 32'd0);
    chk("reset_cont", 32'(CONT_GARRAFAS), 32'd0);
    chk("reset_state", 32'(estado), 32'(OCIOSO));
    RESET = 1'b1;
    tick();

    // Nominal fill and bottle bounce. Row k holds cycle-k inputs and the
    // outputs expected in cycle k+1.
    for (int i = 0; i < 4; i++)   tbl[i] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 4; i < 10; i++)  tbl[i] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 1, 1, 1, 0, 0, 1, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[12] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1);
    tbl[15] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 16; i < 20; i++) tbl[i] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].h, tbl[i].p, tbl[i].n, tbl[i].v, tbl[i].a);
      tick();
      chk($sformatf("tbl%0d_valve", i), 32'(VALVULA_ABERTA), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_cheia", i), 32'(GARRAFA_CHEIA), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_erro", i), 32'(ERRO_ENCHIMENTO), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d_cont", i), 32'(CONT_GARRAFAS), 32'(tbl[i].ecnt));
    end
    chk("bounce_idle", 32'(estado), 32'(OCIOSO));

    // Timeout: the valve stays open for exactly TM cycles.
    start_fill("to_open");
    n_open = 0;
    while (VALVULA_ABERTA === 1'b1 && n_open < 40) begin
      n_open++;
      tick();
    end
    chk("to_open_cycles", 32'(n_open), 32'(TM));
    chk("to_erro", 32'(ERRO_ENCHIMENTO), 32'd1);
    chk("to_valve", 32'(VALVULA_ABERTA), 32'd0);
    drive(1, 1, 0, 1, 1);
    tick();
    chk("to_ack_present", 32'(ERRO_ENCHIMENTO), 32'd1);
    drive(1, 0, 0, 1, 1);
    tick();
    chk("to_ack_removed", 32'(ERRO_ENCHIMENTO), 32'd0);
    chk("to_idle", 32'(estado), 32'(OCIOSO));

    // Level reached on the last allowed cycle is a good fill.
    start_fill("sim_open");
    repeat (TM - 1) tick();
    chk("sim_last_open", 32'(VALVULA_ABERTA), 32'd1);
    drive(1, 1, 1, 1, 0);
    tick();
    chk("sim_cheia", 32'(GARRAFA_CHEIA), 32'd1);
    chk("sim_no_erro", 32'(ERRO_ENCHIMENTO), 32'd0);
    chk("sim_cont", 32'(CONT_GARRAFAS), 32'd2);
    drive(1, 0, 0, 1, 0);
    tick();
    chk("sim_drop", 32'(GARRAFA_CHEIA), 32'd0);

    // Removal wins over the level sensor.
    start_fill("rm_open");
    drive(1, 0, 1, 1, 0);
    tick();
    chk("rm_erro", 32'(ERRO_ENCHIMENTO), 32'd1);
    chk("rm_cont", 32'(CONT_GARRAFAS), 32'd2);
    drive(0, 0, 0, 1, 1);
    tick();
    chk("rm_clear", 32'(ERRO_ENCHIMENTO), 32'd0);

    // Empty tank during seating holds; empty tank during filling is a fault.
    drive(1, 1, 0, 0, 0);
    repeat (10) tick();
    chk("tank_hold_valve", 32'(VALVULA_ABERTA), 32'd0);
    chk("tank_hold_state", 32'(estado), 32'(ASSENTANDO));
    drive(1, 1, 0, 1, 0);
    tick();
    chk("tank_resume", 32'(VALVULA_ABERTA), 32'd1);
    drive(1, 1, 0, 0, 0);
    tick();
    chk("tank_drop_erro", 32'(ERRO_ENCHIMENTO), 32'd1);
    chk("tank_drop_valve", 32'(VALVULA_ABERTA), 32'd0);
    drive(0, 0, 0, 1, 1);
    tick();

    // Asynchronous reset during a fill.
    start_fill("ar_open");
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_valve", 32'(VALVULA_ABERTA), 32'd0);
    chk("ar_cont", 32'(CONT_GARRAFAS), 32'd0);
    #2;
    drive(0, 0, 0, 1, 0);
    RESET = 1'b1;
    tick();

    // Counter wrap.
    repeat ((1 << WC) - 1) fill_one();
    chk("wrap_max", 32'(CONT_GARRAFAS), 32'((1 << WC) - 1));
    fill_one();
    chk("wrap_zero", 32'(CONT_GARRAFAS), 32'd0);

    // Randomized run checked against the model.
    drive(0, 0, 0, 1, 0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    m_stage = ST_IDLE; m_cycles = 0; m_filled = 0;
    p_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic h, n, v, a;
      if ($urandom_range(0, 9) == 0) p_r = ~p_r;
      h = ($urandom_range(0, 19) != 0);
      n = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 24) != 0);
      a = ($urandom_range(0, 3) == 0);
      drive(h, p_r, n, v, a);
      model_step(h, p_r, n, v, a);
      exp_q.push_back({m_stage == ST_FILL, m_stage == ST_FULL, m_stage == ST_FAULT, WC'(m_filled)});
      tick();
      expv = exp_q.pop_front();
      got  = {VALVULA_ABERTA, GARRAFA_CHEIA, ERRO_ENCHIMENTO, CONT_GARRAFAS};
      chk($sformatf("rnd%0d", i), 32'(got), 32'(expv));
      chk("rnd_excl", 32'(VALVULA_ABERTA & GARRAFA_CHEIA), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
